// File: rtl/ghpi_bus_arbiter.sv
// -----------------------------------------------------------------------------
// ghpi_bus_arbiter
//
// Two-master / one-slave arbiter for the generic valid/ack handshake bus, used
// in the Von-Neumann build so the core's IMEM and DMEM ports share one memory.
//
//   Master 0 : core IMEM port (read-only)
//   Master 1 : core DMEM port (read/write)
//   Slave    : unified memory / bus
//
// Exactly one master is routed to the slave at a time. Once a master is granted
// and the slave has not yet acked, the grant is held (LOCK_M0 / LOCK_M1) until
// the slave acks or the master drops its request. A grant issued from IDLE
// that is acked in the same cycle completes with zero added latency.
//
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   m0_addr_i, m0_valid_i        IMEM request
//   m0_data_o, m0_ack_o          IMEM response
//   m1_addr_i, m1_data_i,
//   m1_sel_i, m1_we_i,
//   m1_valid_i                   DMEM request
//   m1_data_o, m1_ack_o          DMEM response
//   s_addr_o, s_data_o, s_sel_o,
//   s_we_o, s_valid_o            slave request
//   s_data_i, s_ack_i            slave response
//
// Build option:
//   ARB_ROUND_ROBIN_EN  - when defined, simultaneous requests in IDLE go to the
//                         master that was not served last. When undefined, M1
//                         (DMEM) always wins. The core keeps IMEM valid high
//                         while it stalls on a DMEM access, so M0 must never be
//                         favoured in the fixed-priority build.
// -----------------------------------------------------------------------------
module ghpi_bus_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                      clk_i,
    input  logic                      rst_i,

    input  logic [ADDR_WIDTH-1:0]     m0_addr_i,
    input  logic                      m0_valid_i,
    output logic [DATA_WIDTH-1:0]     m0_data_o,
    output logic                      m0_ack_o,

    input  logic [ADDR_WIDTH-1:0]     m1_addr_i,
    input  logic [DATA_WIDTH-1:0]     m1_data_i,
    input  logic [DATA_WIDTH/8-1:0]   m1_sel_i,
    input  logic                      m1_we_i,
    input  logic                      m1_valid_i,
    output logic [DATA_WIDTH-1:0]     m1_data_o,
    output logic                      m1_ack_o,

    output logic [ADDR_WIDTH-1:0]     s_addr_o,
    output logic [DATA_WIDTH-1:0]     s_data_o,
    output logic [DATA_WIDTH/8-1:0]   s_sel_o,
    output logic                      s_we_o,
    output logic                      s_valid_o,
    input  logic [DATA_WIDTH-1:0]     s_data_i,
    input  logic                      s_ack_i
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOCK_M0 = 2'd1,
        LOCK_M1 = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_M0   = 2'd1,
        GNT_M1   = 2'd2
    } grant_t;

    state_t state_q, state_d;
    grant_t grant;

`ifdef ARB_ROUND_ROBIN_EN
    // 0 = M0 was served last, 1 = M1 was served last
    logic last_grant_q, last_grant_d;
`endif

    // Effective grant: the locked master, or a fresh arbitration in IDLE.
    always_comb begin
        grant = GNT_NONE;
        case (state_q)
            LOCK_M0: grant = GNT_M0;
            LOCK_M1: grant = GNT_M1;
            default: begin
`ifdef ARB_ROUND_ROBIN_EN
                if (m0_valid_i && m1_valid_i) begin
                    grant = last_grant_q ? GNT_M0 : GNT_M1;
                end else if (m1_valid_i) begin
                    grant = GNT_M1;
                end else if (m0_valid_i) begin
                    grant = GNT_M0;
                end
`else
                if (m1_valid_i) begin
                    grant = GNT_M1;
                end else if (m0_valid_i) begin
                    grant = GNT_M0;
                end
`endif
            end
        endcase
    end

    // Next-state logic. An ack seen together with the IDLE grant completes the
    // transfer without ever entering a LOCK state.
    always_comb begin
        state_d = state_q;
`ifdef ARB_ROUND_ROBIN_EN
        last_grant_d = last_grant_q;
`endif
        case (state_q)
            IDLE: begin
                if (grant == GNT_M0) begin
                    if (s_ack_i) begin
`ifdef ARB_ROUND_ROBIN_EN
                        last_grant_d = 1'b0;
`endif
                    end else begin
                        state_d = LOCK_M0;
                    end
                end else if (grant == GNT_M1) begin
                    if (s_ack_i) begin
`ifdef ARB_ROUND_ROBIN_EN
                        last_grant_d = 1'b1;
`endif
                    end else begin
                        state_d = LOCK_M1;
                    end
                end
            end
            LOCK_M0: begin
                if (s_ack_i) begin
                    state_d = IDLE;
`ifdef ARB_ROUND_ROBIN_EN
                    last_grant_d = 1'b0;
`endif
                end else if (!m0_valid_i) begin
                    // request abandoned: release without delivering an ack
                    state_d = IDLE;
                end
            end
            LOCK_M1: begin
                if (s_ack_i) begin
                    state_d = IDLE;
`ifdef ARB_ROUND_ROBIN_EN
                    last_grant_d = 1'b1;
`endif
                end else if (!m1_valid_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end

    // Slave-side mux. M0 is read-only, so it always presents a full-word read.
    logic                    slv_valid;
    logic                    slv_we;
    logic [ADDR_WIDTH-1:0]   slv_addr;
    logic [DATA_WIDTH-1:0]   slv_data;
    logic [DATA_WIDTH/8-1:0] slv_sel;

    always_comb begin
        slv_valid = 1'b0;
        slv_we    = 1'b0;
        slv_addr  = '0;
        slv_data  = '0;
        slv_sel   = '0;
        case (grant)
            GNT_M0: begin
                slv_valid = m0_valid_i;
                slv_addr  = m0_addr_i;
                slv_sel   = '1;
            end
            GNT_M1: begin
                slv_valid = m1_valid_i;
                slv_we    = m1_we_i;
                slv_addr  = m1_addr_i;
                slv_data  = m1_data_i;
                slv_sel   = m1_sel_i;
            end
            default: ;
        endcase
    end

    // Reset kills the handshake in the same cycle so nothing completes while
    // the FSM is being forced back to IDLE.
    assign s_valid_o = slv_valid & ~rst_i;
    assign s_we_o    = slv_we & ~rst_i;
    assign s_addr_o  = slv_addr;
    assign s_data_o  = slv_data;
    assign s_sel_o   = slv_sel;

    assign m0_data_o = s_data_i;
    assign m1_data_o = s_data_i;
    assign m0_ack_o  = s_ack_i & (grant == GNT_M0) & m0_valid_i & ~rst_i;
    assign m1_ack_o  = s_ack_i & (grant == GNT_M1) & m1_valid_i & ~rst_i;

endmodule

// File: tb/tb_ghpi_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_ghpi_bus_arbiter
//
// Self-checking bench for ghpi_bus_arbiter: a table of directed vectors that
// walk through the multi-cycle handshake scenarios, a round-robin/fixed
// priority sequence, then randomized traffic checked against a reference model
// that tracks only "who owns the bus" and "who was served last".
// -----------------------------------------------------------------------------
module tb_ghpi_bus_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_i;
    logic [AW-1:0] m0_addr_i;
    logic          m0_valid_i;
    logic [DW-1:0] m0_data_o;
    logic          m0_ack_o;
    logic [AW-1:0] m1_addr_i;
    logic [DW-1:0] m1_data_i;
    logic [SW-1:0] m1_sel_i;
    logic          m1_we_i;
    logic          m1_valid_i;
    logic [DW-1:0] m1_data_o;
    logic          m1_ack_o;
    logic [AW-1:0] s_addr_o;
    logic [DW-1:0] s_data_o;
    logic [SW-1:0] s_sel_o;
    logic          s_we_o;
    logic          s_valid_o;
    logic [DW-1:0] s_data_i;
    logic          s_ack_i;

    ghpi_bus_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .m0_addr_i  (m0_addr_i),
        .m0_valid_i (m0_valid_i),
        .m0_data_o  (m0_data_o),
        .m0_ack_o   (m0_ack_o),
        .m1_addr_i  (m1_addr_i),
        .m1_data_i  (m1_data_i),
        .m1_sel_i   (m1_sel_i),
        .m1_we_i    (m1_we_i),
        .m1_valid_i (m1_valid_i),
        .m1_data_o  (m1_data_o),
        .m1_ack_o   (m1_ack_o),
        .s_addr_o   (s_addr_o),
        .s_data_o   (s_data_o),
        .s_sel_o    (s_sel_o),
        .s_we_o     (s_we_o),
        .s_valid_o  (s_valid_o),
        .s_data_i   (s_data_i),
        .s_ack_i    (s_ack_i)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // ---------------- reference model ----------------
    // owner: -1 = nobody holds the bus, 0/1 = that master holds it across cycles
    int owner = -1;
    int last_served = 0;

    function automatic int model_grant();
        if (owner >= 0) return owner;
`ifdef ARB_ROUND_ROBIN_EN
        if (m0_valid_i && m1_valid_i) return (last_served == 0) ? 1 : 0;
`endif
        if (m1_valid_i) return 1;
        if (m0_valid_i) return 0;
        return -1;
    endfunction

    task automatic model_step();
        int g;
        logic req_valid;
        g = model_grant();
        req_valid = (g == 0) ? m0_valid_i : (g == 1) ? m1_valid_i : 1'b0;
        if (rst_i) begin
            owner = -1;
            last_served = 0;
        end else if (g >= 0) begin
            if (s_ack_i) begin
                last_served = g;
                owner = -1;
            end else if (owner < 0) begin
                owner = g;
            end else if (!req_valid) begin
                owner = -1;
            end
        end
    endtask

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_outs(input string tag, input logic esv, input logic [AW-1:0] esa,
                              input logic eswe, input logic [SW-1:0] essel,
                              input logic [DW-1:0] esd, input logic em0, input logic em1);
        check({tag, ".s_valid"}, 64'(s_valid_o), 64'(esv));
        check({tag, ".s_addr"},  64'(s_addr_o),  64'(esa));
        check({tag, ".s_we"},    64'(s_we_o),    64'(eswe));
        check({tag, ".s_sel"},   64'(s_sel_o),   64'(essel));
        check({tag, ".s_data"},  64'(s_data_o),  64'(esd));
        check({tag, ".m0_ack"},  64'(m0_ack_o),  64'(em0));
        check({tag, ".m1_ack"},  64'(m1_ack_o),  64'(em1));
        check({tag, ".m0_data"}, 64'(m0_data_o), 64'(s_data_i));
        check({tag, ".m1_data"}, 64'(m1_data_o), 64'(s_data_i));
    endtask

    // advance one clock; model follows the inputs seen in this cycle
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    typedef struct packed {
        logic          rst;
        logic          m0v;
        logic [AW-1:0] m0a;
        logic          m1v;
        logic [AW-1:0] m1a;
        logic [DW-1:0] m1d;
        logic [SW-1:0] m1s;
        logic          m1w;
        logic          ack;
        logic [DW-1:0] sd;
        logic          esv;
        logic [AW-1:0] esa;
        logic          eswe;
        logic [SW-1:0] essel;
        logic [DW-1:0] esd;
        logic          em0;
        logic          em1;
    } vec_t;

    vec_t vecs[$];

    task automatic apply(input vec_t v);
        rst_i      = v.rst;
        m0_valid_i = v.m0v;
        m0_addr_i  = v.m0a;
        m1_valid_i = v.m1v;
        m1_addr_i  = v.m1a;
        m1_data_i  = v.m1d;
        m1_sel_i   = v.m1s;
        m1_we_i    = v.m1w;
        s_ack_i    = v.ack;
        s_data_i   = v.sd;
    endtask

    initial begin
        rst_i = 1'b1; m0_valid_i = 1'b0; m0_addr_i = '0; m1_valid_i = 1'b0;
        m1_addr_i = '0; m1_data_i = '0; m1_sel_i = '0; m1_we_i = 1'b0;
        s_ack_i = 1'b0; s_data_i = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        owner = -1;
        last_served = 0;

        //          rst  m0v  m0a        m1v  m1a        m1d           m1s    m1w  ack  sd            esv  esa        eswe essel  esd           em0  em1
        // reset state, stray ack ignored
        vecs.push_back('{1'b1,1'b0,32'h0,    1'b0,32'h0,    32'h0,        4'h0,1'b0,1'b1,32'h55,       1'b0,32'h0,    1'b0,4'h0,32'h0,        1'b0,1'b0});
        // zero-latency M0 read
        vecs.push_back('{1'b0,1'b1,32'h100,  1'b0,32'h0,    32'h0,        4'h0,1'b0,1'b1,32'hDEADBEEF, 1'b1,32'h100,  1'b0,4'hF,32'h0,        1'b1,1'b0});
        // FSM stayed in IDLE: a fresh M1 read is served at once
        vecs.push_back('{1'b0,1'b0,32'h0,    1'b1,32'h300,  32'h0,        4'hF,1'b0,1'b1,32'h1111,     1'b1,32'h300,  1'b0,4'hF,32'h0,        1'b0,1'b1});
        // ack with no grant
        vecs.push_back('{1'b0,1'b0,32'h0,    1'b0,32'h0,    32'h0,        4'h0,1'b0,1'b1,32'h2222,     1'b0,32'h0,    1'b0,4'h0,32'h0,        1'b0,1'b0});
        vecs.push_back('{1'b1,1'b0,32'h0,    1'b0,32'h0,    32'h0,        4'h0,1'b0,1'b0,32'h0,        1'b0,32'h0,    1'b0,4'h0,32'h0,        1'b0,1'b0});
        // simultaneous: M1 write first, 2 wait cycles
        vecs.push_back('{1'b0,1'b1,32'h200,  1'b1,32'h300,  32'h12345678, 4'h4,1'b1,1'b0,32'h0,        1'b1,32'h300,  1'b1,4'h4,32'h12345678, 1'b0,1'b0});
        vecs.push_back('{1'b0,1'b1,32'h200,  1'b1,32'h300,  32'h12345678, 4'h4,1'b1,1'b0,32'h0,        1'b1,32'h300,  1'b1,4'h4,32'h12345678, 1'b0,1'b0});
        vecs.push_back('{1'b0,1'b1,32'h200,  1'b1,32'h300,  32'h12345678, 4'h4,1'b1,1'b1,32'hA5A5,     1'b1,32'h300,  1'b1,4'h4,32'h12345678, 1'b0,1'b1});
        // then M0, 2 wait cycles
        vecs.push_back('{1'b0,1'b1,32'h200,  1'b0,32'h0,    32'h0,        4'h0,1'b0,1'b0,32'h0,        1'b1,32'h200,  1'b0,4'hF,32'h0,        1'b0,1'b0});
        vecs.push_back('{1'b0,1'b1,32'h200,  1'b0,32'h0,    32'h0,        4'h0,1'b0,1'b0,32'h0,        1'b1,32'h200,  1'b0,4'hF,32'h0,        1'b0,1'b0});
        vecs.push_back('{1'b0,1'b1,32'h200,  1'b0,32'h0,    32'h0,        4'h0,1'b0,1'b1,32'h0BADF00D, 1'b1,32'h200,  1'b0,4'hF,32'h0,        1'b1,1'b0});
        // lock hold: M0 locked 3 waits, M1 rises mid-lock
        vecs.push_back('{1'b0,1'b1,32'h400,  1'b0,32'h0,    32'h0,        4'h0,1'b0,1'b0,32'h0,        1'b1,32'h400,  1'b0,4'hF,32'h0,        1'b0,1'b0});
        vecs.push_back('{1'b0,1'b1,32'h400,  1'b1,32'h500,  32'h77,       4'h3,1'b1,1'b0,32'h0,        1'b1,32'h400,  1'b0,4'hF,32'h0,        1'b0,1'b0});
        vecs.push_back('{1'b0,1'b1,32'h400,  1'b1,32'h500,  32'h77,       4'h3,1'b1,1'b0,32'h0,        1'b1,32'h400,  1'b0,4'hF,32'h0,        1'b0,1'b0});
        vecs.push_back('{1'b0,1'b1,32'h400,  1'b1,32'h500,  32'h77,       4'h3,1'b1,1'b1,32'h3333,     1'b1,32'h400,  1'b0,4'hF,32'h0,        1'b1,1'b0});
        vecs.push_back('{1'b0,1'b0,32'h0,    1'b1,32'h500,  32'h77,       4'h3,1'b1,1'b0,32'h0,        1'b1,32'h500,  1'b1,4'h3,32'h77,       1'b0,1'b0});
        // abandon: M1 locked, drops valid before ack
        vecs.push_back('{1'b0,1'b0,32'h0,    1'b1,32'h500,  32'h77,       4'h3,1'b1,1'b0,32'h0,        1'b1,32'h500,  1'b1,4'h3,32'h77,       1'b0,1'b0});
        vecs.push_back('{1'b0,1'b1,32'h600,  1'b0,32'h500,  32'h77,       4'h3,1'b1,1'b0,32'h0,        1'b0,32'h500,  1'b1,4'h3,32'h77,       1'b0,1'b0});
        vecs.push_back('{1'b0,1'b1,32'h600,  1'b0,32'h0,    32'h0,        4'h0,1'b0,1'b1,32'h600D,     1'b1,32'h600,  1'b0,4'hF,32'h0,        1'b1,1'b0});
        // reset while LOCK_M1
        vecs.push_back('{1'b0,1'b0,32'h0,    1'b1,32'h700,  32'hCAFE,     4'hF,1'b1,1'b0,32'h0,        1'b1,32'h700,  1'b1,4'hF,32'hCAFE,     1'b0,1'b0});
        vecs.push_back('{1'b1,1'b0,32'h0,    1'b1,32'h700,  32'hCAFE,     4'hF,1'b1,1'b1,32'h4444,     1'b0,32'h700,  1'b0,4'hF,32'hCAFE,     1'b0,1'b0});
        vecs.push_back('{1'b0,1'b1,32'h800,  1'b0,32'h0,    32'h0,        4'h0,1'b0,1'b0,32'h0,        1'b1,32'h800,  1'b0,4'hF,32'h0,        1'b0,1'b0});
        vecs.push_back('{1'b0,1'b1,32'h800,  1'b0,32'h0,    32'h0,        4'h0,1'b0,1'b1,32'h5555,     1'b1,32'h800,  1'b0,4'hF,32'h0,        1'b1,1'b0});
        // address change while locked propagates
        vecs.push_back('{1'b0,1'b1,32'h900,  1'b0,32'h0,    32'h0,        4'h0,1'b0,1'b0,32'h0,        1'b1,32'h900,  1'b0,4'hF,32'h0,        1'b0,1'b0});
        vecs.push_back('{1'b0,1'b1,32'h904,  1'b0,32'h0,    32'h0,        4'h0,1'b0,1'b1,32'h6666,     1'b1,32'h904,  1'b0,4'hF,32'h0,        1'b1,1'b0});

        foreach (vecs[i]) begin
            apply(vecs[i]);
            #3;
            check_outs($sformatf("vec%0d", i), vecs[i].esv, vecs[i].esa, vecs[i].eswe,
                       vecs[i].essel, vecs[i].esd, vecs[i].em0, vecs[i].em1);
            tick();
        end

        // both masters continuously valid, slave acks after one wait cycle
        apply('{1'b1,1'b0,32'h0,1'b0,32'h0,32'h0,4'h0,1'b0,1'b0,32'h0,
                1'b0,32'h0,1'b0,4'h0,32'h0,1'b0,1'b0});
        tick();
        for (int i = 0; i < 8; i++) begin
            int own;
`ifdef ARB_ROUND_ROBIN_EN
            own = ((i / 2) % 2 == 0) ? 1 : 0;
`else
            own = 1;
`endif
            rst_i = 1'b0;
            m0_valid_i = 1'b1; m0_addr_i = 32'hA0;
            m1_valid_i = 1'b1; m1_addr_i = 32'hB0; m1_we_i = 1'b1;
            m1_sel_i = 4'hF; m1_data_i = 32'h11;
            s_ack_i = (i % 2 == 1); s_data_i = 32'h1000 + 32'(i);
            #3;
            check($sformatf("alt%0d.s_addr", i), 64'(s_addr_o), (own == 1) ? 64'hB0 : 64'hA0);
            check($sformatf("alt%0d.m0_ack", i), 64'(m0_ack_o), 64'((own == 0) && (i % 2 == 1)));
            check($sformatf("alt%0d.m1_ack", i), 64'(m1_ack_o), 64'((own == 1) && (i % 2 == 1)));
            tick();
        end

        // randomized traffic against the reference model
        rst_i = 1'b1; s_ack_i = 1'b0;
        tick();
        for (int c = 0; c < 400; c++) begin
            int g;
            logic req_v;
            rst_i      = ($urandom_range(0, 49) == 0);
            m0_valid_i = ($urandom_range(0, 9) < 6);
            m1_valid_i = ($urandom_range(0, 9) < 5);
            m0_addr_i  = $urandom;
            m1_addr_i  = $urandom;
            m1_data_i  = $urandom;
            m1_sel_i   = SW'($urandom);
            m1_we_i    = 1'($urandom);
            s_ack_i    = ($urandom_range(0, 9) < 4);
            s_data_i   = $urandom;
            #3;
            g = model_grant();
            req_v = (g == 0) ? m0_valid_i : (g == 1) ? m1_valid_i : 1'b0;
            check_outs($sformatf("rnd%0d", c),
                       req_v & ~rst_i,
                       (g == 0) ? m0_addr_i : (g == 1) ? m1_addr_i : '0,
                       (g == 1) ? (m1_we_i & ~rst_i) : 1'b0,
                       (g == 0) ? {SW{1'b1}} : (g == 1) ? m1_sel_i : '0,
                       (g == 1) ? m1_data_i : '0,
                       s_ack_i & ~rst_i & (g == 0) & m0_valid_i,
                       s_ack_i & ~rst_i & (g == 1) & m1_valid_i);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/ghpi_bus_arbiter.md
Name: ghpi_bus_arbiter

Overview:
- Two-master, one-slave arbiter for the generic handshaking protocol interface (valid/ack). Used for the Von-Neumann configuration.
- Sits directly downstream of the CPU core.
  - Master 0 = core IMEM port (read-only).
  - Master 1 = core DMEM port (read/write).
  - Slave = single unified memory/bus.
- Routes exactly one master to the slave at a time and holds the grant until the slave acks or the master withdraws.

Parameters:
- ADDR_WIDTH, 32, address width of all ports
- DATA_WIDTH, 32, data width of all ports (sel width = DATA_WIDTH/8)

Ports:
- clk_i  input  1  clock
- rst_i  input  1  reset; synchronous, active-high
- m0_addr_i  input  ADDR_WIDTH  master 0 (IMEM) address
- m0_valid_i  input  1  master 0 request
- m0_data_o  output  DATA_WIDTH  master 0 read data
- m0_ack_o  output  1  master 0 acknowledge
- m1_addr_i  input  ADDR_WIDTH  master 1 (DMEM) address
- m1_data_i  input  DATA_WIDTH  master 1 write data
- m1_sel_i  input  DATA_WIDTH/8  master 1 byte select
- m1_we_i  input  1  master 1 write strobe
- m1_valid_i  input  1  master 1 request
- m1_data_o  output  DATA_WIDTH  master 1 read data
- m1_ack_o  output  1  master 1 acknowledge
- s_addr_o  output  ADDR_WIDTH  slave address
- s_data_o  output  DATA_WIDTH  slave write data
- s_sel_o  output  DATA_WIDTH/8  slave byte select
- s_we_o  output  1  slave write strobe
- s_valid_o  output  1  slave request
- s_data_i  input  DATA_WIDTH  slave read data
- s_ack_i  input  1  slave acknowledge

Behaviour:
- FSM states: IDLE, LOCK_M0, LOCK_M1. Reset → IDLE; last_grant register → M0.
- Effective grant (combinational):
  - IDLE: M1 if m1_valid_i, else M0 if m0_valid_i, else none.
  - LOCK_Mx: Mx.
- Fixed M1 priority is mandatory. The core holds IMEM valid high while it stalls on a DMEM access, so M0 priority would deadlock.
- Zero added latency: if the slave acks in the same cycle as the IDLE grant, the transfer completes that cycle and the FSM stays in IDLE.
- IDLE transitions:
  - Granted, no s_ack_i → LOCK_<granted>.
  - Granted with ack → IDLE; last_grant updated.
- LOCK_Mx transitions:
  - s_ack_i → IDLE; last_grant = x.
  - Mx valid low without ack (abandoned request) → IDLE; no ack is delivered.
  - Otherwise stay.
- While locked, the other master's request is ignored. Its ack stays 0 even if it is valid.
- Slave drive:
  - s_valid_o = granted master's valid.
  - s_addr_o = granted master's address, passed combinationally, so an address change while locked propagates.
  - Grant M0: s_we_o=0, s_sel_o=all ones, s_data_o=0.
  - Grant M1: m1 we/sel/data passed through.
  - No grant: s_valid_o=0, s_we_o=0, s_addr_o=0, s_data_o=0, s_sel_o=0.
- Master return path:
  - m0_data_o = m1_data_o = s_data_i (broadcast).
  - mx_ack_o = s_ack_i & grant==x & mx_valid_i.
- Reset (rst_i high, any state):
  - s_valid_o, s_we_o, m0_ack_o, m1_ack_o forced 0 in that cycle.
  - FSM → IDLE next edge. An in-flight transfer is dropped.
- s_ack_i with no grant is ignored; no ack is generated.
- The FSM never leaves LOCK on the other master's activity.

Optional Feature:
- Macro: ARB_ROUND_ROBIN_EN
- Defined: in IDLE with both valid, grant the master ≠ last_grant; a single requester is granted immediately.
- Undefined: fixed M1 priority as above; last_grant logic may be omitted.

Test Plan:
- Zero-latency M0 read:
  - Stimulus: m0_valid=1, addr=0x100, slave acks same cycle with 0xDEADBEEF, m1 idle.
  - Required: m0_ack_o=1 that cycle, m0_data_o=0xDEADBEEF, FSM stays IDLE.
- Simultaneous requests, macro off:
  - Stimulus: m0 addr 0x200, m1 write addr 0x300 data 0x12345678 sel 0b0100; slave acks after 2 wait cycles each.
  - Required: M1 served first (s_we_o=1, s_sel_o=0b0100), then M0. m0_ack_o=0 throughout M1's lock.
- Lock hold:
  - Stimulus: M0 locked with 3 wait cycles; m1_valid rises during cycle 2.
  - Required: s_addr_o stays M0's address until ack; M1 granted the next cycle.
- Abandon:
  - Stimulus: M1 locked, m1_valid drops before ack.
  - Required: IDLE next cycle, m1_ack_o never 1, M0 granted afterwards.
- Reset mid-transfer:
  - Stimulus: assert rst_i while LOCK_M1.
  - Required: s_valid_o=0, both acks 0 in that cycle; IDLE after the edge.
- ARB_ROUND_ROBIN_EN defined, both masters continuously valid, 1-wait slave:
  - Required: grants alternate M1, M0, M1, M0.
